// File: rtl/ifetch_prefetch_queue_if.sv
// Fetch-side bundle: request/response channel to instruction memory plus the
// valid/ready instruction delivery channel toward the core.
interface ifetch_prefetch_queue_if;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_ready;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// Sequential instruction prefetcher with a DEPTH-entry PC-tagged queue; a response is visible one cycle later.
// Issue is credit-limited so memory responses are never backpressured; the core stalls via inst_ready.
module ifetch_prefetch_queue #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                     CLK,
    input  logic                     resetl,
    input  logic [63:0]              startpc,
    input  logic                     redirect,
    input  logic [63:0]              redirect_pc,
    ifetch_prefetch_queue_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [63:0]   r_fetch_pc;
    logic [63:0]   r_rsp_pc;
    logic [CW-1:0] r_count;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard_cnt;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_q_data [DEPTH];
    logic [63:0]   r_q_pc   [DEPTH];

    logic          w_run;
    logic          w_req_vld;
    logic          w_req_fire;
    logic          w_flush;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_inst_vld;
    logic [31:0]   w_occupancy;
    logic [63:0]   w_redirect_pc;

    // Entries already held plus responses that will be kept must fit the queue.
    assign w_occupancy   = 32'(r_count) + 32'(r_outstanding) - 32'(r_discard_cnt);
    assign w_redirect_pc = redirect_pc & ~64'h3;

    assign w_run      = (r_state == ST_RUN);
    assign w_req_fire = w_req_vld & bus.mem_req_ready;
    assign w_flush    = w_run & redirect;
    assign w_drop     = w_run & !redirect & bus.mem_rsp_valid & (r_discard_cnt != '0);
    assign w_push     = w_run & !redirect & bus.mem_rsp_valid & (r_discard_cnt == '0);
    assign w_inst_vld = (r_count != '0);
    assign w_pop      = w_inst_vld & bus.inst_ready & !w_flush;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_vld   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_req_vld = !redirect
                          && (r_outstanding < OW'(MAX_OUT))
                          && (w_occupancy < 32'(DEPTH));
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_fetch_pc    <= '0;
            r_rsp_pc      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard_cnt <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else if (r_state == ST_BOOT) begin
            r_fetch_pc <= startpc;
            r_rsp_pc   <= startpc;
        end else if (w_flush) begin
            // Everything still in flight, except a word landing right now, is stale.
            r_fetch_pc    <= w_redirect_pc;
            r_rsp_pc      <= w_redirect_pc;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= r_outstanding - OW'(bus.mem_rsp_valid);
            r_discard_cnt <= r_outstanding - OW'(bus.mem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 64'd4;
            end
            r_outstanding <= r_outstanding + OW'(w_req_fire) - OW'(bus.mem_rsp_valid);
            if (w_drop) begin
                r_discard_cnt <= r_discard_cnt - OW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_rsp_pc <= r_rsp_pc + 64'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= bus.mem_rsp_data;
            r_q_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

    assign bus.mem_req_valid = w_req_vld;
    assign bus.mem_req_addr  = r_fetch_pc;
    assign bus.inst_valid    = w_inst_vld;
    assign bus.inst_data     = w_inst_vld ? r_q_data[r_rd_ptr] : 32'd0;
    assign bus.inst_pc       = w_inst_vld ? r_q_pc[r_rd_ptr]   : 64'd0;
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed bench for the prefetch queue with a fixed-latency in-order memory model.
module tb_ifetch_prefetch_queue;
    logic        CLK;
    logic        resetl;
    logic [63:0] startpc;
    logic        redirect;
    logic [63:0] redirect_pc;
    int          lat;
    int          cyc;
    int          n_accepts;
    int          n_tests;
    int          n_fail;

    typedef struct {
        int          due;
        logic [63:0] addr;
    } req_t;
    req_t pend[$];

    ifetch_prefetch_queue_if bus();

    ifetch_prefetch_queue #(.DEPTH(4), .MAX_OUT(4)) dut (
        .CLK         (CLK),
        .resetl      (resetl),
        .startpc     (startpc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    // Memory: a request seen valid&ready in cycle c is answered during cycle c+lat.
    always @(negedge CLK) begin
        if (!resetl) begin
            pend.delete();
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = 32'd0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rsp_data  = 32'd0;
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                pend.push_back('{due: cyc + lat, addr: bus.mem_req_addr});
                n_accepts++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
        #1;
    endtask

    // Leaves the bench one step into the first cycle after reset release (BOOT cycle).
    task automatic do_reset(input logic [63:0] pc);
        resetl      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'd0;
        startpc     = pc;
        n_accepts   = 0;
        repeat (2) @(posedge CLK);
        #1;
        resetl = 1'b1;
    endtask

    task automatic test_reset();
        startpc = 64'h100;
        #1 resetl = 1'b0;
        sample();
        n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", bus.mem_req_valid); end
        n_tests++; if (bus.mem_req_addr !== 64'd0) begin n_fail++; $display("FAIL reset_req_addr got %h want 0", bus.mem_req_addr); end
        n_tests++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got %b want 0", bus.inst_valid); end
        n_tests++; if (bus.inst_data !== 32'd0) begin n_fail++; $display("FAIL reset_inst_data got %h want 0", bus.inst_data); end
        n_tests++; if (bus.inst_pc !== 64'd0) begin n_fail++; $display("FAIL reset_inst_pc got %h want 0", bus.inst_pc); end
        do_reset(64'h100);
        redirect    = 1'b1;
        redirect_pc = 64'h9000;
        sample();
        n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_no_req got %b want 0", bus.mem_req_valid); end
        next_cycle();
        redirect = 1'b0;
        sample();
        n_tests++; if (bus.mem_req_addr !== 64'h100) begin n_fail++; $display("FAIL boot_redirect_ignored got %h want 100", bus.mem_req_addr); end
    endtask

    task automatic test_boot();
        logic [63:0] exp_pc;
        int          pops;
        lat = 1;
        bus.inst_ready = 1'b1;
        do_reset(64'h100);
        sample();
        n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_c0_valid got %b want 0", bus.mem_req_valid); end
        next_cycle(); sample();
        n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h100) begin n_fail++; $display("FAIL boot_c1_req got %b/%h want 1/100", bus.mem_req_valid, bus.mem_req_addr); end
        next_cycle(); sample();
        n_tests++; if (bus.inst_valid !== 1'b0 || bus.mem_req_addr !== 64'h104) begin n_fail++; $display("FAIL boot_c2 got iv=%b addr=%h want 0/104", bus.inst_valid, bus.mem_req_addr); end
        next_cycle(); sample();
        n_tests++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h100) begin n_fail++; $display("FAIL boot_c3_first got iv=%b pc=%h want 1/100", bus.inst_valid, bus.inst_pc); end
        n_tests++; if (bus.inst_data !== mem_word(64'h100)) begin n_fail++; $display("FAIL boot_c3_data got %h want %h", bus.inst_data, mem_word(64'h100)); end
        exp_pc = 64'h104;
        pops   = 0;
        for (int i = 0; i < 10; i++) begin
            next_cycle(); sample();
            if (bus.inst_valid === 1'b1) begin
                n_tests++; if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc)) begin n_fail++; $display("FAIL boot_stream got %h/%h want %h/%h", bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
        end
        n_tests++; if (pops != 10) begin n_fail++; $display("FAIL boot_throughput got %0d want 10", pops); end
    endtask

    task automatic test_full();
        lat = 1;
        bus.inst_ready = 1'b0;
        do_reset(64'h400);
        repeat (12) next_cycle();
        sample();
        n_tests++; if (n_accepts != 4) begin n_fail++; $display("FAIL full_accepts got %0d want 4", n_accepts); end
        n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_req_valid got %b want 0", bus.mem_req_valid); end
        n_tests++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h400) begin n_fail++; $display("FAIL full_head got %b/%h want 1/400", bus.inst_valid, bus.inst_pc); end
        next_cycle();
        bus.inst_ready = 1'b1;
        next_cycle();
        bus.inst_ready = 1'b0;
        repeat (6) next_cycle();
        sample();
        n_tests++; if (n_accepts != 5) begin n_fail++; $display("FAIL full_one_refill got %0d want 5", n_accepts); end
        n_tests++; if (bus.inst_pc !== 64'h404 || bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_after_pop got %h/%b want 404/0", bus.inst_pc, bus.mem_req_valid); end
    endtask

    task automatic test_redirect();
        logic [63:0] exp_pc;
        int          pops;
        lat = 5;
        bus.inst_ready = 1'b1;
        do_reset(64'h1000);
        repeat (4) next_cycle();
        redirect    = 1'b1;
        redirect_pc = 64'h2003;
        sample();
        n_tests++; if (n_accepts != 3) begin n_fail++; $display("FAIL redir_inflight got %0d want 3", n_accepts); end
        n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_no_req got %b want 0", bus.mem_req_valid); end
        next_cycle();
        redirect = 1'b0;
        sample();
        n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h2000) begin n_fail++; $display("FAIL redir_new_req got %b/%h want 1/2000", bus.mem_req_valid, bus.mem_req_addr); end
        exp_pc = 64'h2000;
        pops   = 0;
        for (int i = 0; i < 30; i++) begin
            next_cycle(); sample();
            if (bus.inst_valid === 1'b1) begin
                n_tests++; if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc)) begin n_fail++; $display("FAIL redir_stream got %h/%h want %h/%h", bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
        end
        n_tests++; if (pops < 10) begin n_fail++; $display("FAIL redir_progress got %0d want >=10", pops); end
    endtask

    task automatic test_simultaneous();
        logic [63:0] exp_pc;
        int          pops;
        bit          found;
        lat = 1;
        bus.inst_ready = 1'b1;
        do_reset(64'h3000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            next_cycle();
            if (bus.inst_valid === 1'b1 && pend.size() > 0 && pend[0].due == cyc) found = 1'b1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL simul_setup got 0 want 1"); end
        redirect    = 1'b1;
        redirect_pc = 64'h5000;
        sample();
        n_tests++; if (bus.inst_valid !== 1'b1 || bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL simul_cycle got iv=%b rv=%b want 1/0", bus.inst_valid, bus.mem_req_valid); end
        next_cycle();
        redirect = 1'b0;
        sample();
        n_tests++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL simul_empty got %b want 0", bus.inst_valid); end
        n_tests++; if (bus.mem_req_addr !== 64'h5000) begin n_fail++; $display("FAIL simul_addr got %h want 5000", bus.mem_req_addr); end
        exp_pc = 64'h5000;
        pops   = 0;
        for (int i = 0; i < 10; i++) begin
            next_cycle(); sample();
            if (bus.inst_valid === 1'b1) begin
                n_tests++; if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc)) begin n_fail++; $display("FAIL simul_stream got %h/%h want %h/%h", bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
        end
        n_tests++; if (pops < 5) begin n_fail++; $display("FAIL simul_progress got %0d want >=5", pops); end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_pc [4];
        int          pops;
        exp_pc[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        exp_pc[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_pc[2] = 64'h0;
        exp_pc[3] = 64'h4;
        lat = 1;
        bus.inst_ready = 1'b1;
        do_reset(64'hFFFF_FFFF_FFFF_FFF8);
        pops = 0;
        for (int i = 0; i < 12 && pops < 4; i++) begin
            next_cycle(); sample();
            if (bus.inst_valid === 1'b1) begin
                n_tests++; if (bus.inst_pc !== exp_pc[pops] || bus.inst_data !== mem_word(exp_pc[pops])) begin n_fail++; $display("FAIL wrap_pc got %h/%h want %h/%h", bus.inst_pc, bus.inst_data, exp_pc[pops], mem_word(exp_pc[pops])); end
                pops++;
            end
        end
        n_tests++; if (pops != 4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", pops); end
    endtask

    task automatic test_async_reset();
        bit found;
        lat = 1;
        bus.inst_ready = 1'b0;
        do_reset(64'h6000);
        repeat (5) next_cycle();
        sample();
        n_tests++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h6000) begin n_fail++; $display("FAIL areset_pre got %b/%h want 1/6000", bus.inst_valid, bus.inst_pc); end
        resetl = 1'b0;
        #1;
        n_tests++; if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 64'd0) begin n_fail++; $display("FAIL areset_req got %b/%h want 0/0", bus.mem_req_valid, bus.mem_req_addr); end
        n_tests++; if (bus.inst_valid !== 1'b0 || bus.inst_data !== 32'd0 || bus.inst_pc !== 64'd0) begin n_fail++; $display("FAIL areset_inst got %b/%h/%h want 0/0/0", bus.inst_valid, bus.inst_data, bus.inst_pc); end
        bus.inst_ready = 1'b1;
        do_reset(64'h7000);
        next_cycle(); sample();
        n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h7000) begin n_fail++; $display("FAIL areset_restart got %b/%h want 1/7000", bus.mem_req_valid, bus.mem_req_addr); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            next_cycle(); sample();
            if (bus.inst_valid === 1'b1) begin
                found = 1'b1;
                n_tests++; if (bus.inst_pc !== 64'h7000) begin n_fail++; $display("FAIL areset_first_pc got %h want 7000", bus.inst_pc); end
            end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL areset_timeout got 0 want 1"); end
    endtask

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        n_accepts         = 0;
        lat               = 1;
        resetl            = 1'b1;
        startpc           = 64'd0;
        redirect          = 1'b0;
        redirect_pc       = 64'd0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'd0;
        bus.inst_ready    = 1'b0;
        test_reset();
        test_boot();
        test_full();
        test_redirect();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
